dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 128, meaning the number of 32-bit data words held.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, meaning the wait states between request accept and response.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the MEM stage presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_read, input, 1 bit: load request (MemRead).
REQ-008 SHALL have port req_write, input, 1 bit: store request (MemWrite).
REQ-009 SHALL have port req_addr, input, 32 bits: byte address (Alu_Result).
REQ-010 SHALL have port req_wdata, input, 32 bits: store data (RD_Two), right-aligned.
REQ-011 SHALL have port req_func3, input, 3 bits: access size and sign (func3).
REQ-012 SHALL have port resp_valid, output, 1 bit: one-cycle response strobe.
REQ-013 SHALL have port resp_rdata, output, 32 bits: extended load data (MemReadData).
REQ-014 SHALL have port resp_err, output, 1 bit: the request was rejected and had no side effect.
REQ-015 SHALL have port busy, output, 1 bit: high in WAIT and RESP.

Function
REQ-016 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE; if WAIT_CYCLES=0, IDLE -> RESP directly.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clk edge where req_valid && req_ready.
REQ-018 SHALL latch addr, wdata, func3, read and write on accept and ignore all input changes until the next IDLE.
REQ-019 SHALL count WAIT_CYCLES cycles in WAIT with a 4-bit counter, then enter RESP.
REQ-020 SHALL assert resp_valid for exactly one cycle in RESP, i.e. WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 SHALL hold resp_rdata and resp_err stable from RESP until the next RESP.
REQ-022 SHALL extend loads per func3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero; the byte/half lane is selected by addr[1:0].
REQ-023 SHALL write stores per func3: 000 SB, 001 SH, 010 SW; only the addressed byte lanes change.
REQ-024 SHALL commit a store on the edge entering RESP, so a load accepted in the following IDLE reads the new data.
REQ-025 SHALL set resp_err=1, suppress any write and return rdata=0 on any of: req_read && req_write, illegal func3 for the access type, or addr >= 4*DEPTH_WORDS.
REQ-026 SHALL treat a request with neither read nor write as a no-op: full latency, rdata=0, err=0.
REQ-027 SHALL decode the word index from addr[31:2]; there is no wrap-around, and an out-of-range address is an error per REQ-025.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE, counter=0, req_ready=1 after reset, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
REQ-029 SHALL abandon any in-flight request on reset mid-operation; a store not yet committed SHALL NOT modify memory.
REQ-030 SHALL NOT reset memory contents.

Configuration
REQ-031 SHALL, with DMEM_MISALIGN_CHECK_EN defined, treat LH/LHU/SH at odd addr, or LW/SW with addr[1:0]!=0, as an error per REQ-025.
REQ-032 SHALL, with DMEM_MISALIGN_CHECK_EN undefined, never flag misalignment: halfword accesses use addr[1]-aligned lanes (addr[0] ignored) and word accesses ignore addr[1:0].

Verification
REQ-033 SHALL cover: SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err=0, resp_valid exactly 3 cycles after each accept (WAIT_CYCLES=2).
REQ-034 SHALL cover: SB addr 0x13, wdata 0x000000F0 over word 0x00000000, then LB 0x13 -> 0xFFFFFFF0, LBU 0x13 -> 0x000000F0, LW 0x10 -> 0xF0000000.
REQ-035 SHALL cover: SW addr 0x200 (DEPTH_WORDS=128) -> err=1, then LW 0x1FC -> previous contents unchanged.
REQ-036 SHALL cover: req_read=req_write=1 -> err=1, no write; and func3=011 load -> err=1.
REQ-037 SHALL cover: SW 0x20 accepted, rst_n pulsed low during WAIT -> resp_valid never asserts, and LW 0x20 afterwards returns the old data.
REQ-038 SHALL cover: with DMEM_MISALIGN_CHECK_EN defined, LW 0x22 -> err=1; with it undefined, LW 0x22 -> the word at 0x20, err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, then strobes a one-cycle response.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic        lat_read, lat_write;
    logic [31:0] lat_addr, lat_wdata;
    logic [2:0]  lat_func3;

    logic        in_idle, accept, enter_resp;
    logic        cur_read, cur_write;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_func3;
    logic [AW-1:0] idx;
    logic        in_range, load_ok, store_ok, misalign, err;
    logic [31:0] word, rdata, wr_data;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [3:0]  be;
    logic        we;

    // With zero wait states the response is computed from the live request in IDLE.
    assign in_idle    = (state == S_IDLE);
    assign accept     = in_idle && req_valid;
    assign enter_resp = (WAIT_CYCLES == 0) ? accept : ((state == S_WAIT) && (cnt == LAST_WAIT));
    assign cur_read   = in_idle ? req_read  : lat_read;
    assign cur_write  = in_idle ? req_write : lat_write;
    assign cur_addr   = in_idle ? req_addr  : lat_addr;
    assign cur_wdata  = in_idle ? req_wdata : lat_wdata;
    assign cur_func3  = in_idle ? req_func3 : lat_func3;
    assign idx        = cur_addr[AW+1:2];

    always_comb begin
        in_range = (cur_addr[31:2] < 30'(DEPTH_WORDS));
        load_ok  = (cur_func3 == 3'b000) || (cur_func3 == 3'b001) || (cur_func3 == 3'b010) ||
                   (cur_func3 == 3'b100) || (cur_func3 == 3'b101);
        store_ok = (cur_func3 == 3'b000) || (cur_func3 == 3'b001) || (cur_func3 == 3'b010);
`ifdef DMEM_MISALIGN_CHECK_EN
        case (cur_func3[1:0])
            2'b01:   misalign = cur_addr[0];
            2'b10:   misalign = (cur_addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
`else
        misalign = 1'b0;
`endif
        err = (cur_read && cur_write) || (cur_read && !load_ok) || (cur_write && !store_ok) ||
              ((cur_read || cur_write) && (!in_range || misalign));
    end

    // Load lane selection and extension.
    always_comb begin
        word   = mem[idx];
        byte_v = word[8*cur_addr[1:0] +: 8];
        half_v = word[16*cur_addr[1] +: 16];
        case (cur_func3)
            3'b000:  rdata = {{24{byte_v[7]}}, byte_v};
            3'b001:  rdata = {{16{half_v[15]}}, half_v};
            3'b010:  rdata = word;
            3'b100:  rdata = {24'd0, byte_v};
            3'b101:  rdata = {16'd0, half_v};
            default: rdata = 32'd0;
        endcase
        if (!cur_read || err) rdata = 32'd0;
    end

    // Store lane enables; data is replicated so any enabled lane sees the right bytes.
    always_comb begin
        case (cur_func3[1:0])
            2'b00: begin
                be      = 4'b0001 << cur_addr[1:0];
                wr_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be      = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cur_wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = cur_wdata;
            end
        endcase
        we = rst_n && enter_resp && cur_write && !err;
    end

    // Memory array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_func3  <= 3'd0;
        end else begin
            resp_valid <= 1'b0;
            if (accept) begin
                lat_read  <= req_read;
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_func3 <= req_func3;
            end
            if (enter_resp) begin
                state      <= S_RESP;
                cnt        <= 4'd0;
                req_ready  <= 1'b0;
                busy       <= 1'b1;
                resp_valid <= 1'b1;
                resp_rdata <= rdata;
                resp_err   <= err;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        state     <= S_WAIT;
                        cnt       <= 4'd0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                    S_WAIT: cnt <= cnt + 4'd1;
                    S_RESP: begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at default parameters (DEPTH_WORDS=128, WAIT_CYCLES=2).
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_func3(req_func3), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Issue one request, scramble inputs after accept, return response and latency in cycles.
    task automatic do_req(input logic rd_i, input logic wr_i, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_read = rd_i; req_write = wr_i;
        req_addr = a; req_wdata = wd; req_func3 = f3;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_read = ~rd_i; req_write = ~wr_i;
        req_addr = 32'h0000_0004; req_wdata = 32'hA5A5_A5A5; req_func3 = 3'b111;
        lat = 0; rdata = 32'hxxxx_xxxx; err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_func3 = 3'd0;
        repeat (3) @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", resp_valid); end
        n_tests++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
        n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", resp_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, rd, er, lat);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL sw_latency got %0d exp 3", lat); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_err got %b exp 0", er); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL resp_busy got %b exp 1", busy); end
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency got %0d exp 3", lat); end
        n_tests++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data got %h exp deadbeef", rd); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err got %b exp 0", er); end
        repeat (2) @(negedge clk);
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle got %b exp 0", resp_valid); end
        n_tests++; if (resp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdata_hold got %h exp deadbeef", resp_rdata); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_subword;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 1'b1, 32'h10, 32'h0000_0000, 3'b010, rd, er, lat);
        do_req(1'b0, 1'b1, 32'h13, 32'h0000_00F0, 3'b000, rd, er, lat);
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL sb_err got %b exp 0", er); end
        do_req(1'b1, 1'b0, 32'h13, 32'd0, 3'b000, rd, er, lat);
        n_tests++; if (rd !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL lb_data got %h exp fffffff0", rd); end
        do_req(1'b1, 1'b0, 32'h13, 32'd0, 3'b100, rd, er, lat);
        n_tests++; if (rd !== 32'h0000_00F0) begin n_fail++; $display("FAIL lbu_data got %h exp 000000f0", rd); end
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat);
        n_tests++; if (rd !== 32'hF000_0000) begin n_fail++; $display("FAIL lw_after_sb got %h exp f0000000", rd); end
        do_req(1'b1, 1'b0, 32'h12, 32'd0, 3'b001, rd, er, lat);
        n_tests++; if (rd !== 32'hFFFF_F000) begin n_fail++; $display("FAIL lh_data got %h exp fffff000", rd); end
        do_req(1'b1, 1'b0, 32'h12, 32'd0, 3'b101, rd, er, lat);
        n_tests++; if (rd !== 32'h0000_F000) begin n_fail++; $display("FAIL lhu_data got %h exp 0000f000", rd); end
        do_req(1'b0, 1'b1, 32'h10, 32'hAAAA_1234, 3'b001, rd, er, lat);
        do_req(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, rd, er, lat);
        n_tests++; if (rd !== 32'hF000_1234) begin n_fail++; $display("FAIL sh_word got %h exp f0001234", rd); end
        do_req(1'b1, 1'b0, 32'h11, 32'd0, 3'b000, rd, er, lat);
        n_tests++; if (rd !== 32'h0000_0012) begin n_fail++; $display("FAIL lb_lane1 got %h exp 00000012", rd); end
    endtask

    task automatic test_range;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 1'b1, 32'h1FC, 32'hCAFE_F00D, 3'b010, rd, er, lat);
        do_req(1'b0, 1'b1, 32'h200, 32'h1111_1111, 3'b010, rd, er, lat);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL oob_sw_err got %b exp 1", er); end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL oob_latency got %0d exp 3", lat); end
        do_req(1'b1, 1'b0, 32'h1FC, 32'd0, 3'b010, rd, er, lat);
        n_tests++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL top_word got %h exp cafef00d", rd); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL top_err got %b exp 0", er); end
        do_req(1'b1, 1'b0, 32'h200, 32'd0, 3'b010, rd, er, lat);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL oob_lw_err got %b exp 1", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL oob_lw_data got %h exp 0", rd); end
    endtask

    task automatic test_illegal;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 1'b1, 32'h1FC, 32'h5555_5555, 3'b010, rd, er, lat);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL rw_err got %b exp 1", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rw_data got %h exp 0", rd); end
        do_req(1'b0, 1'b1, 32'h1FC, 32'h6666_6666, 3'b100, rd, er, lat);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL st_f3_err got %b exp 1", er); end
        do_req(1'b1, 1'b0, 32'h1FC, 32'd0, 3'b010, rd, er, lat);
        n_tests++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL no_write got %h exp cafef00d", rd); end
        do_req(1'b1, 1'b0, 32'h1FC, 32'd0, 3'b011, rd, er, lat);
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL ld_f3_err got %b exp 1", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL ld_f3_data got %h exp 0", rd); end
        do_req(1'b0, 1'b0, 32'h1FC, 32'd0, 3'b010, rd, er, lat);
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL noop_err got %b exp 0", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL noop_data got %h exp 0", rd); end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL noop_latency got %0d exp 3", lat); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat; int seen;
        do_req(1'b0, 1'b1, 32'h20, 32'h1111_2222, 3'b010, rd, er, lat);
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
        req_addr = 32'h20; req_wdata = 32'h3333_4444; req_func3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
        seen = 0;
        repeat (2) begin @(negedge clk); if (resp_valid) seen++; end
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (resp_valid) seen++; end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_valid got %0d strobes exp 0", seen); end
        do_req(1'b1, 1'b0, 32'h20, 32'd0, 3'b010, rd, er, lat);
        n_tests++; if (rd !== 32'h1111_2222) begin n_fail++; $display("FAIL midrst_data got %h exp 11112222", rd); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 1'b0, 32'h22, 32'd0, 3'b010, rd, er, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL misalign_err got %b exp 1", er); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL misalign_data got %h exp 0", rd); end
`else
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL misalign_err got %b exp 0", er); end
        n_tests++; if (rd !== 32'h1111_2222) begin n_fail++; $display("FAIL misalign_data got %h exp 11112222", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_range();
        test_illegal();
        test_reset_mid();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
